alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand and result width in bits, with W >= 2.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the accepted-result counter.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: the operand beat is valid.
REQ-006 Port in_ready SHALL be an output, 1 bit wide: the block accepts a beat this cycle.
REQ-007 Port a SHALL be an input, W bits wide: operand A.
REQ-008 Port b SHALL be an input, W bits wide: operand B.
REQ-009 Port sel SHALL be an input, 3 bits wide: the opcode.
REQ-010 Port out_valid SHALL be an output, 1 bit wide: the result beat is valid.
REQ-011 Port out_ready SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-012 Port res SHALL be an output, W bits wide: the result.
REQ-013 Port flags SHALL be an output, 4 bits wide, ordered {carry, overflow, negative, zero}.
REQ-014 Port op_count SHALL be an output, CNT_W bits wide: the number of results accepted, modulo 2^CNT_W.

Function
REQ-015 The opcodes SHALL be: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SHL (a<<b[log2W-1:0]), 110 SHR logical, 111 CMP (computed as SUB; res = a, flags from a-b).
REQ-016 A beat SHALL be accepted when in_valid && in_ready, and a result SHALL transfer when out_valid && out_ready.
REQ-017 The pipeline SHALL have two register stages: S1 captures a, b and sel; S2 captures res and flags. Latency SHALL be 2 cycles from acceptance to out_valid when there is no stall.
REQ-018 stall SHALL be defined as out_valid && !out_ready. S2 loads from S1 when !stall. S1 loads when !stall || !s1_valid.
REQ-019 in_ready SHALL equal !stall || !s1_valid, giving a sustained throughput of 1 beat per cycle with out_ready held high.
REQ-020 During a stall, res and flags SHALL hold stable, and no accepted beat SHALL be dropped or duplicated.
REQ-021 carry SHALL be: for ADD, the carry-out of bit W-1; for SUB and CMP, the borrow (a < b unsigned); for SHL, the last bit shifted out; for SHR, the last bit shifted out; for all other opcodes, 0.
REQ-022 overflow SHALL be the signed two's-complement overflow for ADD, SUB and CMP, and 0 otherwise.
REQ-023 negative SHALL equal res[W-1]; for CMP it SHALL equal bit W-1 of a-b.
REQ-024 zero SHALL be set when res is all-zero; for CMP it SHALL be set when a == b.
REQ-025 A shift amount >= W SHALL be impossible by construction, since only log2(W) bits of b are used.
REQ-026 op_count SHALL increment by 1 on each output transfer and wrap from all-ones to 0.
REQ-027 Simultaneous input acceptance and output transfer in the same cycle SHALL both take effect.

Reset
REQ-028 When rst_n is low, the block SHALL asynchronously clear s1_valid, out_valid, res, flags and op_count to 0.
REQ-029 While rst_n is low, in_ready SHALL be 1 as a consequence of s1_valid = 0.
REQ-030 Any beat in flight when reset asserts SHALL be discarded, and no out_valid pulse SHALL follow the release of reset.

Configuration
REQ-031 When macro ALU_PIPE_SAT_EN is defined, ADD and SUB SHALL saturate: unsigned ADD overflow yields all-ones and SUB underflow yields 0.
REQ-032 When saturation occurs, carry and overflow SHALL still report the unsaturated condition; CMP SHALL be unaffected.
REQ-033 When ALU_PIPE_SAT_EN is not defined, ADD and SUB SHALL wrap modulo 2^W.

Structure
REQ-034 Package alu_pkg SHALL hold the opcode enumeration, the flag bit-index constants and the flags struct type.
REQ-035 Sub-module alu_core SHALL hold the purely combinational datapath (a, b, sel -> res, flags); alu_pipe SHALL hold the handshake, the pipeline registers and the counter.

Verification
REQ-036 With W=8 and no stall, the bench SHALL drive ADD 0x7F+0x01 and check after 2 cycles: res=0x80, overflow=1, negative=1, carry=0.
REQ-037 The bench SHALL drive SUB 0x00-0x01 and check res=0xFF, carry=1; with ALU_PIPE_SAT_EN defined it SHALL check res=0x00, carry=1.
REQ-038 The bench SHALL drive CMP a=0x35, b=0x35 and check res=0x35, zero=1, carry=0; then CMP a=0x10, b=0x20 and check carry=1, zero=0.
REQ-039 The bench SHALL send 5 back-to-back beats with out_ready held low for 4 cycles, then release it and check that in_ready deasserts once both stages are full and that all 5 results emerge in order, unchanged, with op_count=5.
REQ-040 The bench SHALL assert rst_n low mid-stream with 2 beats in flight and check out_valid=0, op_count=0 and no spurious result after release.
REQ-041 The bench SHALL run 65537 transfers with CNT_W=16 and check that op_count wraps to 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU pipe types: opcode enum, flag bit indices and flags bundle.
// Flags are packed {carry, overflow, negative, zero}.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_CMP = 3'b111
   } op_e;

   localparam int FLAG_C = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic negative;
      logic zero;
   } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: a, b, sel -> res, flags.
// Define ALU_PIPE_SAT_EN to make ADD/SUB saturate instead of wrap.
module alu_core
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   sel,
   output logic [W-1:0] res,
   output logic [3:0]   flags
);

   localparam int SHW = $clog2(W);

   op_e            op;
   logic [SHW-1:0] sh;
   logic [W:0]     sum;
   logic [W:0]     diff;
   logic [W:0]     shl;
   logic [W:0]     shr;
   logic           add_v;
   logic           sub_v;
   flags_t         f;

   assign op = op_e'(sel);
   assign sh = b[SHW-1:0];

   always_comb begin
      sum   = {1'b0, a} + {1'b0, b};
      diff  = {1'b0, a} - {1'b0, b};
      // Extra bit on the shifted-out side holds the last bit lost.
      shl   = {1'b0, a} << sh;
      shr   = {a, 1'b0} >> sh;
      add_v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      sub_v = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      res   = '0;
      f     = '0;
      unique case (op)
         OP_ADD: begin
            res        = sum[W-1:0];
            f.carry    = sum[W];
            f.overflow = add_v;
`ifdef ALU_PIPE_SAT_EN
            if (sum[W]) res = '1;
`endif
         end
         OP_SUB: begin
            res        = diff[W-1:0];
            f.carry    = diff[W];
            f.overflow = sub_v;
`ifdef ALU_PIPE_SAT_EN
            if (diff[W]) res = '0;
`endif
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_SHL: begin
            res     = shl[W-1:0];
            f.carry = shl[W];
         end
         OP_SHR: begin
            res     = shr[W:1];
            f.carry = shr[0];
         end
         OP_CMP: begin
            res        = a;
            f.carry    = diff[W];
            f.overflow = sub_v;
         end
         default: ;
      endcase
      f.negative = res[W-1];
      f.zero     = (res == '0);
      if (op == OP_CMP) begin
         f.negative = diff[W-1];
         f.zero     = (a == b);
      end
   end

   assign flags = f;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with accepted-result counter.
// ALU_PIPE_SAT_EN (in alu_core) selects saturating ADD/SUB.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     res,
   output logic [3:0]       flags,
   output logic [CNT_W-1:0] op_count
);

   logic             s1_valid_q, s1_valid_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [2:0]       sel_q, sel_d;
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     res_q, res_d;
   flags_t           flags_q, flags_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [W-1:0]     core_res;
   logic [3:0]       core_flags;
   logic             stall;
   logic             s1_load;

   alu_core #(.W(W)) u_core (
      .a     (a_q),
      .b     (b_q),
      .sel   (sel_q),
      .res   (core_res),
      .flags (core_flags)
   );

   assign stall   = out_valid_q && !out_ready;
   assign s1_load = !stall || !s1_valid_q;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      sel_d       = sel_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      flags_d     = flags_q;
      cnt_d       = cnt_q;
      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            a_d   = a;
            b_d   = b;
            sel_d = sel;
         end
      end
      // S2 only refreshes its payload when a real beat moves in.
      if (!stall) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            res_d   = core_res;
            flags_d = flags_t'(core_flags);
         end
      end
      if (out_valid_q && out_ready) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         flags_q     <= '0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sel_q       <= sel_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         flags_q     <= flags_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready  = s1_load;
   assign out_valid = out_valid_q;
   assign res       = res_q;
   assign flags     = flags_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed table, stall/reset sequences,
// randomized traffic against an arithmetic reference model, counter wrap.
module tb_alu_pipe;

   localparam int W     = 8;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [2:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     res;
   logic [3:0]       flags;
   logic [CNT_W-1:0] op_count;

   alu_pipe #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .flags     (flags),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [W+3:0] exp_cur;
   logic [W+3:0] sb_q[$];
   logic         prev_stall = 1'b0;
   logic [W+3:0] prev_out   = '0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   sel;
      logic [W-1:0] res;
      logic [3:0]   flags;
   } vec_t;

   vec_t tbl[14];

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the opcode rules.
   function automatic logic [W+3:0] model(logic [W-1:0] xa,
                                          logic [W-1:0] xb,
                                          logic [2:0]   xs);
      longint m, ua, ub, sa, sbv, r, sr;
      int     sh;
      logic   c, v, n, z;
      m   = longint'(1) << W;
      ua  = longint'(xa);
      ub  = longint'(xb);
      sa  = (ua >= m / 2) ? ua - m : ua;
      sbv = (ub >= m / 2) ? ub - m : ub;
      sh  = int'(ub % W);
      r   = 0;
      c   = 1'b0;
      v   = 1'b0;
      case (xs)
         3'd0: begin
            r  = ua + ub;
            sr = sa + sbv;
            c  = (r >= m);
            v  = (sr >= m / 2) || (sr < -(m / 2));
            r  = r % m;
`ifdef ALU_PIPE_SAT_EN
            if (c) r = m - 1;
`endif
         end
         3'd1, 3'd7: begin
            r  = ua - ub;
            sr = sa - sbv;
            c  = (ua < ub);
            v  = (sr >= m / 2) || (sr < -(m / 2));
            r  = (r + m) % m;
`ifdef ALU_PIPE_SAT_EN
            if (c && xs == 3'd1) r = 0;
`endif
         end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd5: begin
            r = (ua << sh) % m;
            c = (sh > 0) && (((ua >> (W - sh)) & 1) == 1);
         end
         default: begin
            r = ua >> sh;
            c = (sh > 0) && (((ua >> (sh - 1)) & 1) == 1);
         end
      endcase
      n = (r >= m / 2);
      z = (r == 0);
      if (xs == 3'd7) r = ua;
      return {W'(r), c, v, n, z};
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && out_valid)
            check("stall_hold", 64'({res, flags}), 64'(prev_out));
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL spurious_out: res=%0h flags=%0h, none expected",
                        res, flags);
            end else begin
               check("result", 64'({res, flags}), 64'(sb_q.pop_front()));
            end
         end
         if (in_valid && in_ready) sb_q.push_back(exp_cur);
         prev_stall = out_valid && !out_ready;
         prev_out   = {res, flags};
      end
   end

   task automatic send(logic [W-1:0] xa, logic [W-1:0] xb,
                       logic [2:0] xs, logic [W+3:0] e);
      int   n;
      logic ok;
      n        = 0;
      ok       = 1'b0;
      a        = xa;
      b        = xb;
      sel      = xs;
      exp_cur  = e;
      in_valid = 1'b1;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: in_ready stayed 0, required 1");
      end
   endtask

   task automatic send_rand();
      logic [W-1:0] ra, rb;
      logic [2:0]   rs;
      ra = W'($urandom());
      rb = W'($urandom());
      rs = 3'($urandom());
      send(ra, rb, rs, model(ra, rb, rs));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      check("drain", 64'(sb_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sb_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic seen;
      logic done;

      tbl[0]  = '{8'h7F, 8'h01, 3'd0, 8'h80, 4'b0110};
`ifdef ALU_PIPE_SAT_EN
      tbl[1]  = '{8'h00, 8'h01, 3'd1, 8'h00, 4'b1001};
      tbl[10] = '{8'hFF, 8'h01, 3'd0, 8'hFF, 4'b1010};
`else
      tbl[1]  = '{8'h00, 8'h01, 3'd1, 8'hFF, 4'b1010};
      tbl[10] = '{8'hFF, 8'h01, 3'd0, 8'h00, 4'b1001};
`endif
      tbl[2]  = '{8'h35, 8'h35, 3'd7, 8'h35, 4'b0001};
      tbl[3]  = '{8'h10, 8'h20, 3'd7, 8'h10, 4'b1010};
      tbl[4]  = '{8'hF0, 8'h3C, 3'd2, 8'h30, 4'b0000};
      tbl[5]  = '{8'h00, 8'h00, 3'd3, 8'h00, 4'b0001};
      tbl[6]  = '{8'hAA, 8'h55, 3'd4, 8'hFF, 4'b0010};
      tbl[7]  = '{8'h81, 8'h01, 3'd5, 8'h02, 4'b1000};
      tbl[8]  = '{8'h81, 8'h01, 3'd6, 8'h40, 4'b1000};
      tbl[9]  = '{8'h40, 8'h09, 3'd5, 8'h80, 4'b0010};
      tbl[11] = '{8'h80, 8'h01, 3'd1, 8'h7F, 4'b0100};
      tbl[12] = '{8'hC0, 8'h07, 3'd6, 8'h01, 4'b1000};
      tbl[13] = '{8'h03, 8'h07, 3'd5, 8'h80, 4'b1010};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      sel       = '0;
      exp_cur   = '0;
      done      = 1'b0;
      seen      = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_res", 64'(res), 64'd0);
      check("rst_flags", 64'(flags), 64'd0);
      check("rst_op_count", 64'(op_count), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table; first row also checks the 2-cycle latency.
      for (int i = 0; i < 14; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].sel, {tbl[i].res, tbl[i].flags});
         if (i == 0) begin
            @(negedge clk);
            check("latency_early", 64'(out_valid), 64'd0);
            @(negedge clk);
            check("latency_2cyc", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
         end
      end
      drain();
      check("op_count_table", 64'(op_count), 64'd14);

      // Five back-to-back beats against a 4-cycle output stall.
      do_reset();
      fork
         begin
            for (int i = 0; i < 5; i++) send_rand();
         end
         begin
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("in_ready_full", 64'(in_ready), 64'd0);
            check("out_valid_stall", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("op_count_5", 64'(op_count), 64'd5);

      // Reset with two beats held in the pipe.
      out_ready = 1'b0;
      send_rand();
      send_rand();
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_op_count", 64'(op_count), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("no_spurious_after_rst", 64'(seen), 64'd0);
      @(posedge clk);
      #1;

      // Random traffic with gaps and random backpressure.
      do_reset();
      fork
         begin
            for (int i = 0; i < 2000; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send_rand();
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("op_count_rand", 64'(op_count), 64'd2000);

      // Counter wrap: 65537 transfers leave op_count at 1.
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 65537; i++) send_rand();
      drain();
      check("op_count_wrap", 64'(op_count), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
